// File: rtl/stat_health_mon.sv
// rtl/stat_health_mon.sv - windowed per-word statistics health monitor with sticky alarm
// Optional run-length check: define STAT_HEALTH_MON_RUNLEN_CHECK_EN.
module stat_health_mon #(
  parameter int WORD_SIZE  = 256,
  parameter int BIT_RES    = $clog2(WORD_SIZE),
  parameter int WIN_LEN    = 1024,
  parameter int FAIL_LIMIT = 3,
  localparam int CW = $clog2(WIN_LEN) + 1,
  localparam int FW = $clog2(FAIL_LIMIT) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stat_valid,
  input  logic [BIT_RES-1:0] ones,
  input  logic [BIT_RES-1:0] change_sign_count,
  input  logic [BIT_RES-1:0] ones_max_len,
  input  logic [BIT_RES-1:0] zeros_max_len,
  input  logic [BIT_RES-1:0] ones_lo,
  input  logic [BIT_RES-1:0] ones_hi,
  input  logic [BIT_RES-1:0] cs_lo,
  input  logic [BIT_RES-1:0] cs_hi,
  input  logic [BIT_RES-1:0] run_max,
  input  logic [CW-1:0]      win_fail_tol,
  input  logic               start,
  input  logic               abort,
  input  logic               alarm_clr,
  output logic               busy,
  output logic               done,
  output logic               win_pass,
  output logic [CW-1:0]      fail_cnt,
  output logic [FW-1:0]      consec_fail,
  output logic               alarm
);

  typedef enum logic [1:0] {IDLE, RUN, REPORT} state_t;

  localparam logic [CW-1:0] WIN_LAST = CW'(WIN_LEN - 1);
  localparam logic [CW-1:0] WIN_MAX  = CW'(WIN_LEN);
  localparam logic [FW-1:0] LIMIT    = FW'(FAIL_LIMIT);

  state_t          state, state_nxt;
  logic [CW-1:0]   word_cnt, fail_acc;
  logic            clr_cnt, accept, word_fail, win_fail;
  logic [FW-1:0]   cf_inc;

  always_comb begin
    word_fail = (ones < ones_lo) || (ones > ones_hi) ||
                (change_sign_count < cs_lo) || (change_sign_count > cs_hi);
`ifdef STAT_HEALTH_MON_RUNLEN_CHECK_EN
    word_fail = word_fail || (ones_max_len > run_max) || (zeros_max_len > run_max);
`endif
  end

`ifndef STAT_HEALTH_MON_RUNLEN_CHECK_EN
  logic unused_runlen;
  assign unused_runlen = ^{ones_max_len, zeros_max_len, run_max};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // abort is checked before the word accept so it also beats the final-word transition
  always_comb begin
    state_nxt = state;
    clr_cnt   = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          clr_cnt   = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (stat_valid) begin
          accept = 1'b1;
          if (word_cnt == WIN_LAST) state_nxt = REPORT;
        end
      end
      REPORT: begin
        if (start) begin
          state_nxt = RUN;
          clr_cnt   = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt <= '0;
      fail_acc <= '0;
    end else if (clr_cnt) begin
      word_cnt <= '0;
      fail_acc <= '0;
    end else if (accept) begin
      word_cnt <= word_cnt + 1'b1;
      if (word_fail && (fail_acc != WIN_MAX)) fail_acc <= fail_acc + 1'b1;
    end
  end

  assign win_fail = (fail_acc > win_fail_tol);
  assign cf_inc   = (consec_fail == LIMIT) ? LIMIT : consec_fail + 1'b1;

  // alarm set uses the post-increment count so a saturated streak keeps re-asserting it over alarm_clr
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_pass    <= 1'b0;
      fail_cnt    <= '0;
      consec_fail <= '0;
      alarm       <= 1'b0;
    end else begin
      if (state == REPORT) begin
        win_pass    <= !win_fail;
        fail_cnt    <= fail_acc;
        consec_fail <= win_fail ? cf_inc : '0;
      end
      if ((state == REPORT) && win_fail && (cf_inc == LIMIT)) alarm <= 1'b1;
      else if (alarm_clr)                                     alarm <= 1'b0;
    end
  end

  assign busy = (state == RUN);
  assign done = (state == REPORT);

endmodule
